// File: rtl/tt_gpio_sync.sv
// Controller-side GPIO stage: synchronises, debounces and edge-flags pad inputs; registers pad outputs.
// Optional build macro TT_GPIO_SYNC_EDGE_EN enables the in_rise/in_fall edge registers.
module tt_gpio_sync #(
   parameter int N_PADS      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_PADS-1:0] pad_in,
   output logic [N_PADS-1:0] pad_out,
   output logic [N_PADS-1:0] pad_oeb,
   input  logic [N_PADS-1:0] out_val,
   input  logic [N_PADS-1:0] out_oe,
   input  logic [FILT_W-1:0] filt_len,
   output logic [N_PADS-1:0] in_val,
   output logic [N_PADS-1:0] in_rise,
   output logic [N_PADS-1:0] in_fall
);

   logic [N_PADS-1:0] sync_q [SYNC_STAGES];
   logic [N_PADS-1:0] sync_s;
   logic [FILT_W-1:0] cnt_q  [N_PADS];
   logic [FILT_W-1:0] cnt_d  [N_PADS];
   logic [N_PADS-1:0] in_val_d;

   function automatic logic [FILT_W:0] cnt_inc(input logic [FILT_W-1:0] cnt);
      return {1'b0, cnt} + {{FILT_W{1'b0}}, 1'b1};
   endfunction

   // Widened compare so cnt+1 cannot wrap; filt_len = 0 always expires (bypass).
   function automatic logic cnt_expired(input logic [FILT_W-1:0] cnt,
                                        input logic [FILT_W-1:0] len);
      return cnt_inc(cnt) >= {1'b0, len};
   endfunction

   // Output path: one register stage, no combinational feed-through
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_out <= '0;
         pad_oeb <= '1;
      end else begin
         pad_out <= out_val;
         pad_oeb <= ~out_oe;
      end
   end

   // Synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pad_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      in_val_d = in_val;
      for (int i = 0; i < N_PADS; i++) begin
         logic [FILT_W:0] inc;
         inc      = cnt_inc(cnt_q[i]);
         cnt_d[i] = cnt_q[i];
         if (sync_s[i] == in_val[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_expired(cnt_q[i], filt_len)) begin
            in_val_d[i] = sync_s[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = inc[FILT_W-1:0];
         end
      end
   end

   // Debounce state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_val <= '0;
         for (int i = 0; i < N_PADS; i++) cnt_q[i] <= '0;
      end else begin
         in_val <= in_val_d;
         for (int i = 0; i < N_PADS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef TT_GPIO_SYNC_EDGE_EN
   // Edge pulses land in the same cycle in_val shows the new level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_rise <= '0;
         in_fall <= '0;
      end else begin
         in_rise <= in_val_d & ~in_val;
         in_fall <= ~in_val_d & in_val;
      end
   end
`else
   assign in_rise = '0;
   assign in_fall = '0;
`endif

endmodule

// File: tb/tb_tt_gpio_sync.sv
// Scoreboard bench for tt_gpio_sync: expectations are queued with a due cycle when stimulus is driven.
module tb_tt_gpio_sync;

   localparam int SIG_IN_VAL  = 0;
   localparam int SIG_RISE    = 1;
   localparam int SIG_FALL    = 2;
   localparam int SIG_PAD_OUT = 3;
   localparam int SIG_PAD_OEB = 4;

`ifdef TT_GPIO_SYNC_EDGE_EN
   localparam logic EDGE = 1'b1;
`else
   localparam logic EDGE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pad_in, pad_out, pad_oeb, out_val, out_oe;
   logic [3:0] filt_len;
   logic [7:0] in_val, in_rise, in_fall;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      int         sig;
      logic [7:0] mask;
      logic [7:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];

   tt_gpio_sync #(.N_PADS(8), .SYNC_STAGES(2), .FILT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pad_in   (pad_in),
      .pad_out  (pad_out),
      .pad_oeb  (pad_oeb),
      .out_val  (out_val),
      .out_oe   (out_oe),
      .filt_len (filt_len),
      .in_val   (in_val),
      .in_rise  (in_rise),
      .in_fall  (in_fall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] get_sig(input int sig);
      case (sig)
         SIG_IN_VAL:  return in_val;
         SIG_RISE:    return in_rise;
         SIG_FALL:    return in_fall;
         SIG_PAD_OUT: return pad_out;
         default:     return pad_oeb;
      endcase
   endfunction

   task automatic expect_at(input int c, input int sig, input logic [7:0] mask,
                            input logic [7:0] exp, input string tag);
      exp_t e;
      e.cyc = c; e.sig = sig; e.mask = mask; e.exp = exp & mask; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_due();
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            chk(sb[i].tag, get_sig(sb[i].sig) & sb[i].mask, sb[i].exp);
            sb.delete(i);
         end
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_due();
      end
   endtask

   initial begin
      int n, m, r;
      rst_n    = 1'b0;
      pad_in   = 8'hFF;
      out_val  = 8'hFF;
      out_oe   = 8'hFF;
      filt_len = 4'd0;

      // reset with all inputs high
      expect_at(3, SIG_IN_VAL,  8'hFF, 8'h00, "rst_in_val");
      expect_at(3, SIG_PAD_OUT, 8'hFF, 8'h00, "rst_pad_out");
      expect_at(3, SIG_PAD_OEB, 8'hFF, 8'hFF, "rst_pad_oeb");
      expect_at(3, SIG_RISE,    8'hFF, 8'h00, "rst_in_rise");
      expect_at(3, SIG_FALL,    8'hFF, 8'h00, "rst_in_fall");
      tick(3);

      pad_in  = 8'h00;
      out_val = 8'h00;
      out_oe  = 8'h00;
      rst_n   = 1'b1;
      tick(5);

      // output path: one cycle, not earlier
      n = cyc;
      out_val = 8'hA5;
      out_oe  = 8'h0F;
      #1;
      chk("pad_out_early", pad_out, 8'h00);
      chk("pad_oeb_early", pad_oeb, 8'hFF);
      expect_at(n + 1, SIG_PAD_OUT, 8'hFF, 8'hA5, "pad_out_n1");
      expect_at(n + 1, SIG_PAD_OEB, 8'hFF, 8'hF0, "pad_oeb_n1");
      tick(2);

      // bypass latency on pad 0
      n = cyc;
      pad_in[0] = 1'b1;
      expect_at(n + 2, SIG_IN_VAL, 8'h01, 8'h00, "byp_val_n2");
      expect_at(n + 3, SIG_IN_VAL, 8'h01, 8'h01, "byp_val_n3");
      expect_at(n + 2, SIG_RISE,   8'h01, 8'h00, "byp_rise_n2");
      expect_at(n + 3, SIG_RISE,   8'h01, {7'd0, EDGE}, "byp_rise_n3");
      expect_at(n + 4, SIG_RISE,   8'h01, 8'h00, "byp_rise_n4");
      expect_at(n + 3, SIG_FALL,   8'h01, 8'h00, "byp_fall_n3");
      tick(6);

      // filter length 3: short glitch rejected
      filt_len = 4'd3;
      tick(2);
      n = cyc;
      pad_in[3] = 1'b1;
      for (int k = 1; k <= 8; k++) expect_at(n + k, SIG_IN_VAL, 8'h08, 8'h00, "glitch_rej");
      tick(2);
      pad_in[3] = 1'b0;
      tick(8);

      // filter length 3: sustained level commits 3 cycles after sync output rises
      m = cyc;
      pad_in[3] = 1'b1;
      expect_at(m + 4, SIG_IN_VAL, 8'h08, 8'h00, "filt_val_m4");
      expect_at(m + 5, SIG_IN_VAL, 8'h08, 8'h08, "filt_val_m5");
      expect_at(m + 5, SIG_RISE,   8'h08, {4'd0, EDGE, 3'd0}, "filt_rise_m5");
      expect_at(m + 6, SIG_RISE,   8'h08, 8'h00, "filt_rise_m6");
      tick(8);

      // falling edge in bypass
      filt_len = 4'd0;
      tick(1);
      n = cyc;
      pad_in[3] = 1'b0;
      expect_at(n + 2, SIG_IN_VAL, 8'h08, 8'h08, "fall_val_n2");
      expect_at(n + 3, SIG_IN_VAL, 8'h08, 8'h00, "fall_val_n3");
      expect_at(n + 3, SIG_FALL,   8'h08, {4'd0, EDGE, 3'd0}, "fall_pulse_n3");
      expect_at(n + 4, SIG_FALL,   8'h08, 8'h00, "fall_pulse_n4");
      expect_at(n + 3, SIG_RISE,   8'h08, 8'h00, "fall_norise_n3");
      tick(6);

      // lowering filt_len mid-count commits on the next cycle
      filt_len = 4'd8;
      tick(1);
      m = cyc;
      pad_in[1] = 1'b1;
      expect_at(m + 4, SIG_IN_VAL, 8'h02, 8'h00, "shrink_val_m4");
      expect_at(m + 5, SIG_IN_VAL, 8'h02, 8'h02, "shrink_val_m5");
      tick(4);
      filt_len = 4'd1;
      tick(3);

      // reset mid-count discards the pending change
      pad_in[1] = 1'b0;
      tick(5);
      filt_len = 4'd8;
      pad_in[1] = 1'b1;
      tick(5);
      rst_n = 1'b0;
      #1;
      chk("async_rst_in_val",  in_val,  8'h00);
      chk("async_rst_pad_out", pad_out, 8'h00);
      chk("async_rst_pad_oeb", pad_oeb, 8'hFF);
      tick(2);
      r = cyc;
      rst_n = 1'b1;
      expect_at(r + 9,  SIG_IN_VAL, 8'h02, 8'h00, "restart_val_r9");
      expect_at(r + 10, SIG_IN_VAL, 8'h02, 8'h02, "restart_val_r10");
      tick(12);

      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         bad++;
         $display("FAIL %s: never checked, due cycle %0d expected %h", e.tag, e.cyc, e.exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
